// File: rtl/usb_pkg.sv
// Shared USB encoder types and constants.
package usb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        STUFF = 2'd2
    } stuff_state_e;

    // A stuffed 0 follows the sixth consecutive 1.
    localparam int MAX_ONES = 6;
    localparam int ONES_W   = 3;
    localparam int CNT_W    = 8;

endpackage

// File: rtl/bit_stuffer_encode_if.sv
// Bit stream in from the CRC stage, stuffed stream out toward the NRZI encoder.
interface bit_stuffer_encode_if;
    import usb_pkg::*;

    logic             in_valid;
    logic             in_bit;
    logic             in_ready;
    logic             out_bit;
    logic             out_valid;
    logic [CNT_W-1:0] stuff_cnt;

    modport master (
        output in_valid, in_bit,
        input  in_ready, out_bit, out_valid, stuff_cnt
    );

    modport slave (
        input  in_valid, in_bit,
        output in_ready, out_bit, out_valid, stuff_cnt
    );

endinterface

// File: rtl/bit_stuffer_encode_fsm.sv
// Packet/stuff sequencing for the bit stuffer; the datapath lives in the top.
module bit_stuffer_encode_fsm
    import usb_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic              in_bit,
    input  logic [ONES_W-1:0] ones_cnt,
    output stuff_state_e      state,
    output logic              in_ready
);

    stuff_state_e next_state;
    logic         run_full;

    // Accepting this 1 completes a run of MAX_ONES.
    assign run_full = in_bit && (ones_cnt == ONES_W'(MAX_ONES - 1));

    always_ff @(posedge clock) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b1;
        case (state)
            IDLE: begin
                if (in_valid) next_state = SEND;
            end
            SEND: begin
                if (!in_valid)    next_state = IDLE;
                else if (run_full) next_state = STUFF;
            end
            STUFF: begin
                // Entered even if the packet ended on the sixth 1.
                in_ready   = 1'b0;
                next_state = SEND;
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: rtl/bit_stuffer_encode.sv
// USB bit stuffer: inserts a 0 after every six consecutive 1s of a packet.
module bit_stuffer_encode
    import usb_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset_n,
    bit_stuffer_encode_if.slave  bus
);

    stuff_state_e      state;
    logic              in_ready;
    logic              accept;
    logic              pkt_start;
    logic              stuffing;
    logic [ONES_W-1:0] ones_cnt;
    logic              out_bit;
    logic              out_valid;
    logic [CNT_W-1:0]  stuff_cnt;

    bit_stuffer_encode_fsm u_fsm (
        .clock    (clock),
        .reset_n  (reset_n),
        .in_valid (bus.in_valid),
        .in_bit   (bus.in_bit),
        .ones_cnt (ones_cnt),
        .state    (state),
        .in_ready (in_ready)
    );

    assign accept    = bus.in_valid & in_ready;
    assign pkt_start = (state == IDLE) & bus.in_valid;
    assign stuffing  = (state == STUFF);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ones_cnt  <= '0;
            out_bit   <= 1'b0;
            out_valid <= 1'b0;
            stuff_cnt <= '0;
        end else begin
            if (pkt_start)                     stuff_cnt <= '0;
            else if (stuffing && stuff_cnt != '1) stuff_cnt <= stuff_cnt + 1'b1;

            if (accept) begin
                out_bit   <= bus.in_bit;
                out_valid <= 1'b1;
                // The sixth 1 wraps the run back to zero; the stuff cycle follows.
                ones_cnt  <= (bus.in_bit && ones_cnt != ONES_W'(MAX_ONES - 1))
                             ? ones_cnt + 1'b1 : '0;
            end else if (stuffing) begin
                out_bit   <= 1'b0;
                out_valid <= 1'b1;
            end else begin
                out_bit   <= 1'b0;
                out_valid <= 1'b0;
                ones_cnt  <= '0;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_bit   = out_bit;
    assign bus.out_valid = out_valid;
    assign bus.stuff_cnt = stuff_cnt;

endmodule

// File: doc/bit_stuffer_encode.md
BIT_STUFFER_ENCODE -- requirements
Module: bit_stuffer_encode

Interface
REQ-001: clock  input  1  single clock; all state updates on rising edge.
REQ-002: reset_n  input  1  reset is synchronous and active-low.
REQ-003: in_valid  input  1  upstream (CRC stage) presents a packet bit this cycle; high continuously for the whole packet.
REQ-004: in_bit  input  1  packet bit, sampled only when in_valid & in_ready.
REQ-005: in_ready  output  1  combinational; low means upstream holds in_bit and in_valid unchanged.
REQ-006: out_bit  output  1  registered bitstream toward the NRZI encoder; 0 when out_valid is low.
REQ-007: out_valid  output  1  registered; high while a bit (data or stuffed) is on out_bit.
REQ-008: stuff_cnt  output  8  stuffed bits inserted in the current packet; saturates at 255.

Function
REQ-009: The FSM shall have states IDLE, SEND and STUFF.
REQ-010: in_ready shall be 1 in IDLE and SEND, and 0 in STUFF.
REQ-011: A bit is accepted when in_valid & in_ready; the accepted bit shall appear on out_bit with out_valid=1 on the next cycle (latency 1).
REQ-012: A 3-bit ones counter shall increment on each accepted 1 and clear on each accepted 0.
REQ-013: IDLE with in_valid=1 shall accept the bit, clear stuff_cnt, and go to SEND; the first packet bit counts toward the ones run.
REQ-014: SEND, accepted 1 with ones counter = 5: output that 1 next cycle, clear the counter, and go to STUFF.
REQ-015: STUFF: no accept; register out_bit=0, out_valid=1 for the next cycle; increment stuff_cnt (saturating); go to SEND.
REQ-016: The stuffed 0 shall immediately follow the sixth 1 with no gap in out_valid.
REQ-017: SEND with in_valid=0: register out_valid=0 and out_bit=0, clear the ones counter, and go to IDLE; stuff_cnt holds until the next packet starts.
REQ-018: A packet ending on a sixth 1 shall still emit the stuffed 0 (STUFF is entered regardless of in_valid); the FSM then returns to SEND and, if in_valid=0, to IDLE.
REQ-019: A run of 1s across a stuffed 0 restarts counting from zero after the stuff.
REQ-020: The ones counter never exceeds 5 at the start of a cycle.

Reset
REQ-021: While reset_n=0 at a clock edge: state=IDLE, ones counter=0, stuff_cnt=0, out_bit=0, out_valid=0.
REQ-022: in_ready shall read 1 after reset.
REQ-023: Reset asserted in any state, including STUFF, aborts the packet; no pending stuffed bit is emitted after reset.

Structure
REQ-024: The state enum and the constant MAX_ONES=6 shall live in the shared usb_pkg package.
REQ-025: The FSM shall be a sub-module, bit_stuffer_encode_fsm; the datapath (ones counter, output register, stuff_cnt) shall live in the top module.

Verification
REQ-026: Bits 1,1,1,1,1,1,1,0 -> out 1,1,1,1,1,1,0,1,0; in_ready low exactly one cycle; stuff_cnt=1.
REQ-027: Twelve 1s -> 14 output bits with 0 at positions 7 and 14; stuff_cnt=2.
REQ-028: Bits 1,1,1,1,1,0,1,1,1,1,1 -> output identical to input with 1-cycle latency; in_ready never low; stuff_cnt=0.
REQ-029: Packet of six 1s, then in_valid=0 -> out 1×6, then 0, then out_valid=0 next cycle; state IDLE.
REQ-030: reset_n=0 during STUFF -> next edge out_valid=0, in_ready=1, stuff_cnt=0; the next packet counts ones from zero.
REQ-031: 300 consecutive 1s -> stuff_cnt reads 50; with 1,600 consecutive 1s, stuff_cnt saturates at 255, with no wrap.
